// File: rtl/dmem_lsu.sv
// Load/store unit: RV32I byte/half/word loads with extension, sb/sh via two-cycle read-modify-write.
// Optional macro MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of ignoring low address bits.
module dmem_lsu #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  input  logic              req_we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              stall_o,
  output logic [31:0]       load_data_o,
  output logic              load_valid_o,
  output logic              misalign_err_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wd_o,
  input  logic [31:0]       mem_rd_i
);

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic [31:0]       load_data_q, load_data_d;
  logic              load_valid_q, load_valid_d;
  logic              misalign_q, misalign_d;
  logic              stall_s, mem_we_s, capture_s, mis_s;
  logic [31:0]       mem_wd_s;

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = lo[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0000, h};
      3'b010:  return rd;
      default: return 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [2:0] f3, input logic [1:0] lo,
                                              input logic [31:0] word, input logic [15:0] wd);
    case (f3)
      3'b000: begin
        case (lo)
          2'd0:    return {word[31:8], wd[7:0]};
          2'd1:    return {word[31:16], wd[7:0], word[7:0]};
          2'd2:    return {word[31:24], wd[7:0], word[15:0]};
          default: return {wd[7:0], word[23:0]};
        endcase
      end
      3'b001:  return lo[1] ? {wd[15:0], word[15:0]} : {word[31:16], wd[15:0]};
      default: return word;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  // Half ops (h, hu, sh) need addr[0]=0; word ops need addr[1:0]=0.
  assign mis_s = ((funct3_i == 3'b001) && addr_i[0]) ||
                 ((funct3_i == 3'b101) && !req_we_i && addr_i[0]) ||
                 ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
`else
  assign mis_s = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    stall_s      = 1'b0;
    mem_we_s     = 1'b0;
    mem_wd_s     = wdata_i;
    capture_s    = 1'b0;
    load_valid_d = 1'b0;
    load_data_d  = load_data_q;
    misalign_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (mis_s) begin
            misalign_d = 1'b1;
            if (!req_we_i) begin
              load_valid_d = 1'b1;
              load_data_d  = 32'h0000_0000;
            end else begin
              load_valid_d = 1'b0;
            end
          end else if (!req_we_i) begin
            load_valid_d = 1'b1;
            load_data_d  = load_extend(funct3_i, addr_i[1:0], mem_rd_i);
          end else begin
            case (funct3_i)
              3'b010: mem_we_s = 1'b1;
              3'b000, 3'b001: begin
                stall_s   = 1'b1;
                capture_s = 1'b1;
                state_d   = MERGE;
              end
              default: mem_we_s = 1'b0;
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      MERGE: begin
        mem_we_s = 1'b1;
        mem_wd_s = merge_lanes(funct3_q, addr_q[1:0], word_q, wdata_q);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Pending write must vanish the instant reset rises, even mid-MERGE.
    if (rst) begin
      stall_s  = 1'b0;
      mem_we_s = 1'b0;
    end else begin
      stall_s  = stall_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      word_q       <= 32'h0000_0000;
      addr_q       <= '0;
      wdata_q      <= 16'h0000;
      funct3_q     <= 3'b000;
      load_data_q  <= 32'h0000_0000;
      load_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_data_q  <= load_data_d;
      load_valid_q <= load_valid_d;
      misalign_q   <= misalign_d;
      if (capture_s) begin
        word_q   <= mem_rd_i;
        addr_q   <= addr_i;
        wdata_q  <= wdata_i[15:0];
        funct3_q <= funct3_i;
      end
    end
  end

  assign stall_o        = stall_s;
  assign mem_we_o       = mem_we_s;
  assign mem_wd_o       = mem_wd_s;
  assign mem_a_o        = (state_q == MERGE) ? {addr_q[ADDR_W-1:2], 2'b00}
                                             : {addr_i[ADDR_W-1:2], 2'b00};
  assign load_data_o    = load_data_q;
  assign load_valid_o   = load_valid_q;
  assign misalign_err_o = misalign_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu with a small word-wide data memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [15:0] addr = 16'h0000;
  logic [31:0] wdata = 32'h0;
  logic        stall, load_valid, misalign_err, mem_we;
  logic [31:0] load_data, mem_wd, mem_rd;
  logic [15:0] mem_a;
  logic        init_mem = 1'b0;
  logic [31:0] mem [0:63];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_we_i(req_we),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
    .load_data_o(load_data), .load_valid_o(load_valid), .misalign_err_o(misalign_err),
    .mem_a_o(mem_a), .mem_we_o(mem_we), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];

  always @(posedge clk) begin
    if (init_mem) begin
      mem[4] <= 32'h8899_AABB;
      mem[5] <= 32'h1122_3344;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [2:0] f3,
                       input logic [15:0] a, input logic [31:0] wd);
    req_valid = v; req_we = we; funct3 = f3; addr = a; wdata = wd;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'b010, 16'h0010, 32'hFFFF_FFFF);
    #3;
    n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", stall); end
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    n_cmp++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL rst_load_valid got %b want 0", load_valid); end
    n_cmp++; if (load_data !== 32'h0) begin n_err++; $display("FAIL rst_load_data got %h want 0", load_data); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL rst_misalign got %b want 0", misalign_err); end
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    init_mem = 1'b1;
    step();
    init_mem = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s [7] = '{3'b000, 3'b101, 3'b001, 3'b010, 3'b100, 3'b000, 3'b011};
    logic [15:0] as  [7] = '{16'h0013, 16'h0010, 16'h0012, 16'h0010, 16'h0011, 16'h0010, 16'h0010};
    logic [31:0] exp [7] = '{32'hFFFF_FF88, 32'h0000_AABB, 32'hFFFF_8899, 32'h8899_AABB,
                             32'h0000_00AA, 32'hFFFF_FFBB, 32'h0000_0000};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, f3s[i], as[i], 32'h0);
      #2;
      n_cmp++; if (mem_we !== 1'b0 || stall !== 1'b0) begin
        n_err++; $display("FAIL load%0d_ctrl got we=%b stall=%b want 0 0", i, mem_we, stall);
      end
      step();
      n_cmp++; if (load_valid !== 1'b1 || load_data !== exp[i]) begin
        n_err++; $display("FAIL load%0d got v=%b %h want v=1 %h", i, load_valid, load_data, exp[i]);
      end
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    step();
    n_cmp++; if (load_valid !== 1'b0) begin n_err++; $display("FAIL load_idle_valid got %b want 0", load_valid); end
  endtask

  task automatic test_sb();
    drive(1'b1, 1'b1, 3'b000, 16'h0011, 32'h1234_56CC);
    #2;
    n_cmp++; if (stall !== 1'b1 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL sb_read got stall=%b we=%b want 1 0", stall, mem_we);
    end
    step();
    wdata = 32'h0000_0000;
    #2;
    n_cmp++; if (stall !== 1'b0 || mem_we !== 1'b1 || mem_wd !== 32'h8899_CCBB || mem_a !== 16'h0010) begin
      n_err++; $display("FAIL sb_merge got stall=%b we=%b wd=%h a=%h want 0 1 8899ccbb 0010",
                        stall, mem_we, mem_wd, mem_a);
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    step();
    n_cmp++; if (mem[4] !== 32'h8899_CCBB) begin n_err++; $display("FAIL sb_mem got %h want 8899ccbb", mem[4]); end
    n_cmp++; if (stall !== 1'b0 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL sb_idle got stall=%b we=%b want 0 0", stall, mem_we);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 3'b001, 16'h0012, 32'hDEAD_BEEF);
    #2;
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_sh_stall got %b want 1", stall); end
    step();
    n_cmp++; if (stall !== 1'b0 || mem_we !== 1'b1 || mem_wd !== 32'hBEEF_CCBB) begin
      n_err++; $display("FAIL b2b_sh_merge got stall=%b we=%b wd=%h want 0 1 beefccbb", stall, mem_we, mem_wd);
    end
    step();
    drive(1'b1, 1'b1, 3'b010, 16'h0014, 32'hCAFE_F00D);
    #2;
    n_cmp++; if (stall !== 1'b0 || mem_we !== 1'b1 || mem_wd !== 32'hCAFE_F00D || mem_a !== 16'h0014) begin
      n_err++; $display("FAIL b2b_sw got stall=%b we=%b wd=%h a=%h want 0 1 cafef00d 0014",
                        stall, mem_we, mem_wd, mem_a);
    end
    step();
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    n_cmp++; if (mem[4] !== 32'hBEEF_CCBB || mem[5] !== 32'hCAFE_F00D) begin
      n_err++; $display("FAIL b2b_mem got %h %h want beefccbb cafef00d", mem[4], mem[5]);
    end
  endtask

  task automatic test_rst_merge();
    drive(1'b1, 1'b1, 3'b000, 16'h0010, 32'h0000_0077);
    step();
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rstm_pre_we got %b want 1", mem_we); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0 || stall !== 1'b0) begin
      n_err++; $display("FAIL rstm_drop got we=%b stall=%b want 0 0", mem_we, stall);
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    step();
    rst = 1'b0;
    n_cmp++; if (mem[4] !== 32'hBEEF_CCBB) begin n_err++; $display("FAIL rstm_mem got %h want beefccbb", mem[4]); end
    drive(1'b1, 1'b0, 3'b010, 16'h0010, 32'h0);
    step();
    n_cmp++; if (load_valid !== 1'b1 || load_data !== 32'hBEEF_CCBB) begin
      n_err++; $display("FAIL rstm_idle_load got v=%b %h want 1 beefccbb", load_valid, load_data);
    end
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    step();
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b0, 3'b010, 16'h0011, 32'h0);
    step();
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (load_valid !== 1'b1 || load_data !== 32'h0 || misalign_err !== 1'b1) begin
      n_err++; $display("FAIL mis_lw got v=%b %h err=%b want 1 00000000 1", load_valid, load_data, misalign_err);
    end
`else
    n_cmp++; if (load_valid !== 1'b1 || load_data !== 32'hBEEF_CCBB || misalign_err !== 1'b0) begin
      n_err++; $display("FAIL mis_lw got v=%b %h err=%b want 1 beefccbb 0", load_valid, load_data, misalign_err);
    end
`endif
    drive(1'b0, 1'b0, 3'b000, 16'h0000, 32'h0);
    step();
    n_cmp++; if (misalign_err !== 1'b0) begin n_err++; $display("FAIL mis_pulse got %b want 0", misalign_err); end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_sb();
    test_back_to_back();
    test_rst_merge();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
